mux_bram: RTL and testbench
===========================

MUX_BRAM -- requirements
Module: mux_bram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width.
REQ-002 SHALL have parameter ADDR_W, default 16, address width of all ports.
REQ-003 SHALL have parameter DEPTH, default 512, main-memory words.
REQ-004 SHALL have parameter VDEPTH, default 512, VRAM words.
REQ-005 SHALL have parameter NI, default 2, range 1..4, instruction read channels.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port gwe  in  1  global write enable; gates data writes.
REQ-009 SHALL have port ireq  in  NI  per-channel instruction read request, level, held until ivalid.
REQ-010 SHALL have port iaddr  in  NI*ADDR_W  per-channel address, channel k at bits [k*ADDR_W +: ADDR_W], stable while ireq[k] high.
REQ-011 SHALL have port ivalid  out  NI  one-cycle pulse per channel: read data ready.
REQ-012 SHALL have port iout  out  NI*DATA_W  per-channel read data, same packing as iaddr.
REQ-013 SHALL have ports dre in 1, dwe in 1, daddr in ADDR_W, din in DATA_W: data read/write request, level, held until dvalid.
REQ-014 SHALL have ports dvalid out 1 (one-cycle completion pulse) and dout out DATA_W (held data read result).
REQ-015 SHALL have ports vaddr in ADDR_W and vout out DATA_W: video read port.
REQ-016 SHALL have port slot out 3, the current slot index, for debug.

Function
REQ-017 Single physical memory port SHALL be time-multiplexed by a slot counter cycling 0,1,...,NI, then wrapping to 0; slot k<NI serves channel k and slot NI serves the data port.
REQ-018 In slot k with ireq[k]=1, memory SHALL be read at iaddr[k]; one cycle later ivalid[k]=1 and iout[k] SHALL equal that word.
REQ-019 iout[k] SHALL hold its last value until the next ivalid[k]; ivalid[k] is 0 in all other cycles.
REQ-020 In slot NI with dre=1, a read SHALL complete with dvalid=1 and dout updated one cycle later; dout holds otherwise.
REQ-021 In slot NI with dwe=1 and gwe=1, din SHALL be written at daddr; dvalid SHALL pulse one cycle later and dout is unchanged.
REQ-022 If dre and dwe are both 1 in slot NI, the write SHALL take effect and dout SHALL return the pre-write word (read-first).
REQ-023 dwe=1 with gwe=0 SHALL perform no write, and dvalid SHALL still pulse.
REQ-024 A channel whose request is low in its slot SHALL produce no ivalid/dvalid pulse and leave the slot idle; worst-case latency from request to valid SHALL be NI+2 cycles.
REQ-025 A write with daddr[ADDR_W-1:ADDR_W-2]==2'b11 SHALL also write VRAM at daddr mod VDEPTH in the same cycle.
REQ-026 vout SHALL equal VRAM at vaddr mod VDEPTH one cycle after vaddr is presented, every cycle (no slot dependency).
REQ-027 A VRAM write and a video read to the same index in the same cycle SHALL return old data on vout.
REQ-028 Addresses >= DEPTH SHALL ignore writes and return 0 on reads; the range check is done before truncation, with no aliasing.

Reset
REQ-029 While rst_n=0 at a clock edge: slot=0; ivalid, dvalid=0; iout, dout, vout=0.
REQ-030 Reset SHALL NOT clear main memory or VRAM contents.
REQ-031 An access whose slot fell in a reset cycle SHALL be dropped: no valid pulse and no write; the requester re-presents it.

Structure
REQ-032 Shared package mux_bram_pkg SHALL hold the slot index width function and the VRAM window constant 2'b11.
REQ-033 Per-channel holding registers SHALL be instances of the existing Nbit_reg; there SHALL be no other sub-module.
REQ-034 Memory arrays SHALL infer block RAM with synchronous read; no combinational array read.

Verification
REQ-035 Preload mem[0x0010]=0xBEEF, ireq[0]=1, iaddr[0]=0x0010 from reset -> ivalid[0] at cycle 1, iout[0]=0xBEEF, held afterwards.
REQ-036 NI=2, all requests high, distinct addresses -> ivalid[0], ivalid[1], dvalid pulse in cycles 1, 2, 3, repeating every 3 cycles.
REQ-037 dwe=dre=1, gwe=1, daddr=0x0020 (old 0x1111), din=0x2222 -> dout=0x1111; a later read returns 0x2222.
REQ-038 dwe=1, daddr=0xC005, din=0xABCD, then vaddr=0x0005 -> vout=0xABCD next cycle; same-cycle collision returns old value.
REQ-039 gwe=0 write to 0x0030 -> dvalid pulses, memory unchanged; read of daddr=0x0300 (>=DEPTH) returns 0.
REQ-040 rst_n low during a data slot with dwe=1 -> no write, no dvalid, slot=0, all outputs 0 after the edge.

Source files
------------

// File: rtl/mux_bram_pkg.sv
// Shared constants and helpers for the slot-multiplexed BRAM.
package mux_bram_pkg;

    // Upper two address bits that select the video window on writes.
    localparam logic [1:0] VRAM_WIN = 2'b11;

    // Width of a counter that must hold slot indices 0..ni.
    function automatic int slot_w(input int ni);
        return (ni < 1) ? 1 : $clog2(ni + 1);
    endfunction

endpackage

// File: rtl/Nbit_reg.sv
// Generic n-bit register with synchronous active-high reset and gated write enable.
module Nbit_reg #(
    parameter int           n = 1,
    parameter logic [n-1:0] r = '0
) (
    input  logic [n-1:0] in,
    output logic [n-1:0] out,
    input  logic         clk,
    input  logic         we,
    input  logic         gwe,
    input  logic         rst
);

    always_ff @(posedge clk) begin
        if (rst)            out <= r;
        else if (we && gwe) out <= in;
    end

endmodule

// File: rtl/mux_bram.sv
// Single-port main memory shared round-robin between NI instruction channels and
// one data port, plus a separate VRAM with its own always-on video read port.
module mux_bram
    import mux_bram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 512,
    parameter int VDEPTH = 512,
    parameter int NI     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 gwe,
    input  logic [NI-1:0]        ireq,
    input  logic [NI*ADDR_W-1:0] iaddr,
    output logic [NI-1:0]        ivalid,
    output logic [NI*DATA_W-1:0] iout,
    input  logic                 dre,
    input  logic                 dwe,
    input  logic [ADDR_W-1:0]    daddr,
    input  logic [DATA_W-1:0]    din,
    output logic                 dvalid,
    output logic [DATA_W-1:0]    dout,
    input  logic [ADDR_W-1:0]    vaddr,
    output logic [DATA_W-1:0]    vout,
    output logic [2:0]           slot
);

    localparam int             SW     = slot_w(NI);
    localparam int             MW     = $clog2(DEPTH);
    localparam int             VW     = $clog2(VDEPTH);
    localparam logic [SW-1:0]  SLOT_D = SW'(NI);

    logic              rst;
    logic [SW-1:0]     slot_q, slot_d;
    logic [NI-1:0]     acc_ich;
    logic              acc_dat;
    logic [ADDR_W-1:0] acc_addr;
    logic              in_rng;
    logic              mem_we, vram_we;
    logic [MW-1:0]     mem_idx;
    logic [VW-1:0]     vw_idx, vr_idx;

    assign rst = ~rst_n;

    always_comb begin
        slot_d = (slot_q == SLOT_D) ? '0 : slot_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) slot_q <= '0;
        else        slot_q <= slot_d;
    end

    assign slot = 3'(slot_q);

    // Owner of the memory port this cycle; the data address is the default mux leg.
    always_comb begin
        acc_ich  = '0;
        acc_dat  = 1'b0;
        acc_addr = daddr;
        for (int k = 0; k < NI; k++) begin
            if (slot_q == SW'(k)) begin
                acc_ich[k] = ireq[k];
                acc_addr   = iaddr[k*ADDR_W +: ADDR_W];
            end
        end
        if (slot_q == SLOT_D) acc_dat = dre | dwe;
    end

    // Full-width compare so out-of-range addresses never alias onto low words.
    assign in_rng  = ({1'b0, acc_addr} < (ADDR_W+1)'(DEPTH));
    assign mem_idx = acc_addr[MW-1:0];
    assign mem_we  = rst_n && (slot_q == SLOT_D) && dwe && gwe && in_rng;
    assign vram_we = rst_n && (slot_q == SLOT_D) && dwe && gwe
                     && (daddr[ADDR_W-1 -: 2] == VRAM_WIN);
    assign vw_idx  = VW'(daddr % ADDR_W'(VDEPTH));
    assign vr_idx  = VW'(vaddr % ADDR_W'(VDEPTH));

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_rd_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= din;
        mem_rd_q <= mem_q[mem_idx];
    end

    logic [DATA_W-1:0] vram_q [VDEPTH];
    logic [DATA_W-1:0] vout_q;

    always_ff @(posedge clk) begin
        if (vram_we) vram_q[vw_idx] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vout_q <= '0;
        else        vout_q <= vram_q[vr_idx];
    end

    assign vout = vout_q;

    logic [NI-1:0] ich_q;
    logic          dat_q, dre_q, inr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ich_q <= '0;
            dat_q <= 1'b0;
            dre_q <= 1'b0;
            inr_q <= 1'b0;
        end else begin
            ich_q <= acc_ich;
            dat_q <= acc_dat;
            dre_q <= dre;
            inr_q <= in_rng;
        end
    end

    logic [DATA_W-1:0] rd_word;
    logic              dload;

    assign rd_word = inr_q ? mem_rd_q : '0;
    assign ivalid  = ich_q;
    assign dvalid  = dat_q;
    assign dload   = dat_q & dre_q;

    // Outputs bypass the hold register on the valid cycle, then show the held copy.
    logic [NI-1:0][DATA_W-1:0] ihold;

    for (genvar k = 0; k < NI; k++) begin : g_ich
        Nbit_reg #(.n(DATA_W)) u_ihold (
            .in  (rd_word),
            .out (ihold[k]),
            .clk (clk),
            .we  (ich_q[k]),
            .gwe (1'b1),
            .rst (rst)
        );
        assign iout[k*DATA_W +: DATA_W] = ich_q[k] ? rd_word : ihold[k];
    end

    logic [DATA_W-1:0] dhold;

    Nbit_reg #(.n(DATA_W)) u_dhold (
        .in  (rd_word),
        .out (dhold),
        .clk (clk),
        .we  (dload),
        .gwe (1'b1),
        .rst (rst)
    );

    assign dout = dload ? rd_word : dhold;

endmodule

// File: tb/tb_mux_bram.sv
// Directed bench for mux_bram at default parameters (NI=2, DEPTH=512).
module tb_mux_bram;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NI = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             gwe   = 1'b1;
    logic [NI-1:0]    ireq  = '0;
    logic [NI*AW-1:0] iaddr = '0;
    logic [NI-1:0]    ivalid;
    logic [NI*DW-1:0] iout;
    logic             dre   = 1'b0;
    logic             dwe   = 1'b0;
    logic [AW-1:0]    daddr = '0;
    logic [DW-1:0]    din   = '0;
    logic             dvalid;
    logic [DW-1:0]    dout;
    logic [AW-1:0]    vaddr = '0;
    logic [DW-1:0]    vout;
    logic [2:0]       slot;

    mux_bram dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .gwe    (gwe),
        .ireq   (ireq),
        .iaddr  (iaddr),
        .ivalid (ivalid),
        .iout   (iout),
        .dre    (dre),
        .dwe    (dwe),
        .daddr  (daddr),
        .din    (din),
        .dvalid (dvalid),
        .dout   (dout),
        .vaddr  (vaddr),
        .vout   (vout),
        .slot   (slot)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] rd, vo;

    // Presents a data request at a negedge and waits at most NI+2 cycles for dvalid.
    task automatic data_op(input logic re, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output logic [DW-1:0] r,
                           output logic [DW-1:0] v);
        bit seen = 0;
        r = '0;
        v = '0;
        dre = re; dwe = we; daddr = a; din = d;
        for (int i = 0; i < NI + 2 && !seen; i++) begin
            @(negedge clk);
            if (dvalid) begin
                seen = 1;
                r = dout;
                v = vout;
            end
        end
        dre = 1'b0;
        dwe = 1'b0;
        chk("dvalid_seen", 32'(seen), 32'd1);
    endtask

    logic [2:0] pat [6];

    initial begin
        pat = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_slot",   32'(slot),   32'd0);
        chk("rst_ivalid", 32'(ivalid), 32'd0);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_iout",   iout,        32'd0);
        chk("rst_dout",   32'(dout),   32'd0);
        chk("rst_vout",   32'(vout),   32'd0);

        rst_n = 1'b1;
        data_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, rd, vo);
        data_op(1'b0, 1'b1, 16'h0020, 16'h1111, rd, vo);
        data_op(1'b0, 1'b1, 16'h0030, 16'h5555, rd, vo);
        data_op(1'b0, 1'b1, 16'h0040, 16'h4444, rd, vo);
        data_op(1'b0, 1'b1, 16'h0050, 16'h7777, rd, vo);
        data_op(1'b0, 1'b1, 16'h0100, 16'h6666, rd, vo);

        // Channel 0 read straight out of reset; memory must survive the reset.
        rst_n = 1'b0;
        ireq  = 2'b01;
        iaddr[15:0] = 16'h0010;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("i0_c0_ivalid", 32'(ivalid), 32'd0);
        @(negedge clk);
        chk("i0_c1_ivalid", 32'(ivalid), 32'b01);
        chk("i0_c1_iout",   32'(iout[15:0]), 32'hBEEF);
        chk("i0_c1_slot",   32'(slot), 32'd1);
        ireq = 2'b00;
        @(negedge clk);
        chk("i0_c2_ivalid", 32'(ivalid), 32'd0);
        chk("i0_c2_hold",   32'(iout[15:0]), 32'hBEEF);
        @(negedge clk);
        chk("i0_c3_hold",   32'(iout[15:0]), 32'hBEEF);

        // All requesters active: pulses rotate ch0, ch1, data every three cycles.
        rst_n = 1'b0;
        ireq  = 2'b11;
        iaddr = {16'h0040, 16'h0010};
        daddr = 16'h0050;
        dre   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rr_c%0d", c + 1), 32'({ivalid, dvalid}), 32'(pat[c]));
            if (c == 0) chk("rr_iout0", 32'(iout[15:0]),  32'hBEEF);
            if (c == 1) chk("rr_iout1", 32'(iout[31:16]), 32'h4444);
            if (c == 2) chk("rr_dout",  32'(dout),        32'h7777);
        end
        ireq = 2'b00;
        dre  = 1'b0;

        // Read-first on simultaneous read/write.
        data_op(1'b1, 1'b1, 16'h0020, 16'h2222, rd, vo);
        chk("rf_old", 32'(rd), 32'h1111);
        data_op(1'b1, 1'b0, 16'h0020, 16'h0000, rd, vo);
        chk("rf_new", 32'(rd), 32'h2222);

        // Write with gwe low is dropped but still completes.
        gwe = 1'b0;
        data_op(1'b0, 1'b1, 16'h0030, 16'h9999, rd, vo);
        gwe = 1'b1;
        data_op(1'b1, 1'b0, 16'h0030, 16'h0000, rd, vo);
        chk("gwe0_keep", 32'(rd), 32'h5555);
        data_op(1'b1, 1'b0, 16'h0300, 16'h0000, rd, vo);
        chk("oor_read", 32'(rd), 32'h0000);
        data_op(1'b0, 1'b1, 16'h0300, 16'hDEAD, rd, vo);
        data_op(1'b1, 1'b0, 16'h0100, 16'h0000, rd, vo);
        chk("oor_noalias", 32'(rd), 32'h6666);

        // VRAM window write, then read and same-cycle collision.
        data_op(1'b0, 1'b1, 16'hC005, 16'hABCD, rd, vo);
        vaddr = 16'h0005;
        @(negedge clk);
        chk("vram_rd", 32'(vout), 32'hABCD);
        data_op(1'b0, 1'b1, 16'hC005, 16'h1234, rd, vo);
        chk("vram_coll_old", 32'(vo), 32'hABCD);
        @(negedge clk);
        chk("vram_coll_new", 32'(vout), 32'h1234);

        // Reset landing on a data write slot drops the write and the pulse.
        begin
            bit found = 0;
            for (int i = 0; i < 5 && !found; i++) begin
                if (slot == 3'd2) found = 1;
                else @(negedge clk);
            end
            chk("find_dslot", 32'(found), 32'd1);
        end
        rst_n = 1'b0;
        dwe   = 1'b1;
        daddr = 16'h0020;
        din   = 16'hBAD0;
        @(negedge clk);
        chk("rd_slot",   32'(slot),   32'd0);
        chk("rd_dvalid", 32'(dvalid), 32'd0);
        chk("rd_dout",   32'(dout),   32'd0);
        chk("rd_iout",   iout,        32'd0);
        chk("rd_vout",   32'(vout),   32'd0);
        dwe   = 1'b0;
        rst_n = 1'b1;
        data_op(1'b1, 1'b0, 16'h0020, 16'h0000, rd, vo);
        chk("rd_nowrite", 32'(rd), 32'h2222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
